id_ex_reg: RTL and testbench

- ID/EX pipeline register of the RV32I 5-stage core.
- Captures the 4-bit ALU control code from the ALU decoder, register operands, immediate, PC and the main-decoder control bits at the end of ID, and presents them to EX one cycle later.
- Implements load-use stall (hold) and branch/jump flush (bubble insertion).
- Keeps a saturating bubble counter for performance debug.

---
 rtl/id_ex_reg.sv | 204 ++++++++++++++++++++
 tb/tb_id_ex_reg.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: carries ID-stage operands and decoded controls into EX.
// Latency: 1 cycle from *_D to *_E when neither stall_E nor flush_E is asserted.
// Backpressure: stall_E holds every register; flush_E overrides stall_E and inserts a bubble.
//
// Ports:
//   clk, rst_n        pipeline clock, synchronous active-low reset
//   stall_E, flush_E  hazard-unit hold / bubble requests (flush wins)
//   *_D               ID-stage instruction fields, valid_D marks a real instruction
//   *_E               registered copies presented to EX, valid_E marks a real instruction
//   bubble_cnt        saturating count of flush bubbles since reset
module id_ex_reg #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_E,
    input  logic             flush_E,
    input  logic             valid_D,
    input  logic [3:0]       ALUControl_D,
    input  logic             RegWrite_D,
    input  logic             MemWrite_D,
    input  logic             Jump_D,
    input  logic             Branch_D,
    input  logic             ALUSrc_D,
    input  logic [1:0]       ResultSrc_D,
    input  logic [2:0]       funct3_D,
    input  logic [XLEN-1:0]  RD1_D,
    input  logic [XLEN-1:0]  RD2_D,
    input  logic [XLEN-1:0]  ImmExt_D,
    input  logic [XLEN-1:0]  PC_D,
    input  logic [XLEN-1:0]  PCPlus4_D,
    input  logic [4:0]       Rs1_D,
    input  logic [4:0]       Rs2_D,
    input  logic [4:0]       Rd_D,
    output logic             valid_E,
    output logic [3:0]       ALUControl_E,
    output logic             RegWrite_E,
    output logic             MemWrite_E,
    output logic             Jump_E,
    output logic             Branch_E,
    output logic             ALUSrc_E,
    output logic [1:0]       ResultSrc_E,
    output logic [2:0]       funct3_E,
    output logic [XLEN-1:0]  RD1_E,
    output logic [XLEN-1:0]  RD2_E,
    output logic [XLEN-1:0]  ImmExt_E,
    output logic [XLEN-1:0]  PC_E,
    output logic [XLEN-1:0]  PCPlus4_E,
    output logic [4:0]       Rs1_E,
    output logic [4:0]       Rs2_E,
    output logic [4:0]       Rd_E,
    output logic [CNT_W-1:0] bubble_cnt
);

    logic             valid_q,      valid_d;
    logic [3:0]       alu_ctrl_q,   alu_ctrl_d;
    logic             reg_write_q,  reg_write_d;
    logic             mem_write_q,  mem_write_d;
    logic             jump_q,       jump_d;
    logic             branch_q,     branch_d;
    logic             alu_src_q,    alu_src_d;
    logic [1:0]       result_src_q, result_src_d;
    logic [2:0]       funct3_q,     funct3_d;
    logic [XLEN-1:0]  rd1_q,        rd1_d;
    logic [XLEN-1:0]  rd2_q,        rd2_d;
    logic [XLEN-1:0]  imm_ext_q,    imm_ext_d;
    logic [XLEN-1:0]  pc_q,         pc_d;
    logic [XLEN-1:0]  pc_plus4_q,   pc_plus4_d;
    logic [4:0]       rs1_q,        rs1_d;
    logic [4:0]       rs2_q,        rs2_d;
    logic [4:0]       rd_q,         rd_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        // Default: hold (covers stall_E without flush_E).
        valid_d      = valid_q;
        alu_ctrl_d   = alu_ctrl_q;
        reg_write_d  = reg_write_q;
        mem_write_d  = mem_write_q;
        jump_d       = jump_q;
        branch_d     = branch_q;
        alu_src_d    = alu_src_q;
        result_src_d = result_src_q;
        funct3_d     = funct3_q;
        rd1_d        = rd1_q;
        rd2_d        = rd2_q;
        imm_ext_d    = imm_ext_q;
        pc_d         = pc_q;
        pc_plus4_d   = pc_plus4_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        rd_d         = rd_q;
        bubble_cnt_d = bubble_cnt_q;

        if (flush_E) begin
            // Full bubble: ALU op = add and Rd = x0, so nothing downstream
            // (writeback, memory, forwarding) can react to it.
            valid_d      = 1'b0;
            alu_ctrl_d   = 4'b0000;
            reg_write_d  = 1'b0;
            mem_write_d  = 1'b0;
            jump_d       = 1'b0;
            branch_d     = 1'b0;
            alu_src_d    = 1'b0;
            result_src_d = 2'b00;
            funct3_d     = 3'b000;
            rd1_d        = '0;
            rd2_d        = '0;
            imm_ext_d    = '0;
            pc_d         = '0;
            pc_plus4_d   = '0;
            rs1_d        = '0;
            rs2_d        = '0;
            rd_d         = '0;
            if (bubble_cnt_q != {CNT_W{1'b1}}) begin
                bubble_cnt_d = bubble_cnt_q + 1'b1;
            end
        end else if (!stall_E) begin
            valid_d      = valid_D;
            // ALU code is forwarded verbatim, reserved encodings included.
            alu_ctrl_d   = ALUControl_D;
            // Main-decoder controls are squashed for an ID bubble so stale
            // decode values never produce side effects in later stages.
            reg_write_d  = valid_D & RegWrite_D;
            mem_write_d  = valid_D & MemWrite_D;
            jump_d       = valid_D & Jump_D;
            branch_d     = valid_D & Branch_D;
            alu_src_d    = valid_D & ALUSrc_D;
            result_src_d = valid_D ? ResultSrc_D : 2'b00;
            funct3_d     = funct3_D;
            rd1_d        = RD1_D;
            rd2_d        = RD2_D;
            imm_ext_d    = ImmExt_D;
            pc_d         = PC_D;
            pc_plus4_d   = PCPlus4_D;
            rs1_d        = Rs1_D;
            rs2_d        = Rs2_D;
            rd_d         = Rd_D;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            alu_ctrl_q   <= 4'b0000;
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            jump_q       <= 1'b0;
            branch_q     <= 1'b0;
            alu_src_q    <= 1'b0;
            result_src_q <= 2'b00;
            funct3_q     <= 3'b000;
            rd1_q        <= '0;
            rd2_q        <= '0;
            imm_ext_q    <= '0;
            pc_q         <= '0;
            pc_plus4_q   <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rd_q         <= '0;
            bubble_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            alu_ctrl_q   <= alu_ctrl_d;
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            jump_q       <= jump_d;
            branch_q     <= branch_d;
            alu_src_q    <= alu_src_d;
            result_src_q <= result_src_d;
            funct3_q     <= funct3_d;
            rd1_q        <= rd1_d;
            rd2_q        <= rd2_d;
            imm_ext_q    <= imm_ext_d;
            pc_q         <= pc_d;
            pc_plus4_q   <= pc_plus4_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            rd_q         <= rd_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign valid_E      = valid_q;
    assign ALUControl_E = alu_ctrl_q;
    assign RegWrite_E   = reg_write_q;
    assign MemWrite_E   = mem_write_q;
    assign Jump_E       = jump_q;
    assign Branch_E     = branch_q;
    assign ALUSrc_E     = alu_src_q;
    assign ResultSrc_E  = result_src_q;
    assign funct3_E     = funct3_q;
    assign RD1_E        = rd1_q;
    assign RD2_E        = rd2_q;
    assign ImmExt_E     = imm_ext_q;
    assign PC_E         = pc_q;
    assign PCPlus4_E    = pc_plus4_q;
    assign Rs1_E        = rs1_q;
    assign Rs2_E        = rs2_q;
    assign Rd_E         = rd_q;
    assign bubble_cnt   = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: reset, load, stall, flush, flush+stall,
// ID bubble, reserved ALU codes and bubble counter saturation (CNT_W=4 copy).
module tb_id_ex_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_E, flush_E, valid_D;
    logic [3:0]  ALUControl_D;
    logic        RegWrite_D, MemWrite_D, Jump_D, Branch_D, ALUSrc_D;
    logic [1:0]  ResultSrc_D;
    logic [2:0]  funct3_D;
    logic [31:0] RD1_D, RD2_D, ImmExt_D, PC_D, PCPlus4_D;
    logic [4:0]  Rs1_D, Rs2_D, Rd_D;

    logic        valid_E;
    logic [3:0]  ALUControl_E;
    logic        RegWrite_E, MemWrite_E, Jump_E, Branch_E, ALUSrc_E;
    logic [1:0]  ResultSrc_E;
    logic [2:0]  funct3_E;
    logic [31:0] RD1_E, RD2_E, ImmExt_E, PC_E, PCPlus4_E;
    logic [4:0]  Rs1_E, Rs2_E, Rd_E;
    logic [15:0] bubble_cnt;

    // Second instance with a 4-bit counter for saturation; its other outputs are unchecked.
    logic        s_valid_E;
    logic [3:0]  s_ALUControl_E;
    logic        s_RegWrite_E, s_MemWrite_E, s_Jump_E, s_Branch_E, s_ALUSrc_E;
    logic [1:0]  s_ResultSrc_E;
    logic [2:0]  s_funct3_E;
    logic [31:0] s_RD1_E, s_RD2_E, s_ImmExt_E, s_PC_E, s_PCPlus4_E;
    logic [4:0]  s_Rs1_E, s_Rs2_E, s_Rd_E;
    logic [3:0]  bubble_cnt4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    id_ex_reg #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .stall_E(stall_E), .flush_E(flush_E), .valid_D(valid_D),
        .ALUControl_D(ALUControl_D), .RegWrite_D(RegWrite_D), .MemWrite_D(MemWrite_D),
        .Jump_D(Jump_D), .Branch_D(Branch_D), .ALUSrc_D(ALUSrc_D), .ResultSrc_D(ResultSrc_D),
        .funct3_D(funct3_D), .RD1_D(RD1_D), .RD2_D(RD2_D), .ImmExt_D(ImmExt_D), .PC_D(PC_D),
        .PCPlus4_D(PCPlus4_D), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rd_D(Rd_D),
        .valid_E(valid_E), .ALUControl_E(ALUControl_E), .RegWrite_E(RegWrite_E),
        .MemWrite_E(MemWrite_E), .Jump_E(Jump_E), .Branch_E(Branch_E), .ALUSrc_E(ALUSrc_E),
        .ResultSrc_E(ResultSrc_E), .funct3_E(funct3_E), .RD1_E(RD1_E), .RD2_E(RD2_E),
        .ImmExt_E(ImmExt_E), .PC_E(PC_E), .PCPlus4_E(PCPlus4_E), .Rs1_E(Rs1_E),
        .Rs2_E(Rs2_E), .Rd_E(Rd_E), .bubble_cnt(bubble_cnt)
    );

    id_ex_reg #(.XLEN(32), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .stall_E(stall_E), .flush_E(flush_E), .valid_D(valid_D),
        .ALUControl_D(ALUControl_D), .RegWrite_D(RegWrite_D), .MemWrite_D(MemWrite_D),
        .Jump_D(Jump_D), .Branch_D(Branch_D), .ALUSrc_D(ALUSrc_D), .ResultSrc_D(ResultSrc_D),
        .funct3_D(funct3_D), .RD1_D(RD1_D), .RD2_D(RD2_D), .ImmExt_D(ImmExt_D), .PC_D(PC_D),
        .PCPlus4_D(PCPlus4_D), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rd_D(Rd_D),
        .valid_E(s_valid_E), .ALUControl_E(s_ALUControl_E), .RegWrite_E(s_RegWrite_E),
        .MemWrite_E(s_MemWrite_E), .Jump_E(s_Jump_E), .Branch_E(s_Branch_E),
        .ALUSrc_E(s_ALUSrc_E), .ResultSrc_E(s_ResultSrc_E), .funct3_E(s_funct3_E),
        .RD1_E(s_RD1_E), .RD2_E(s_RD2_E), .ImmExt_E(s_ImmExt_E), .PC_E(s_PC_E),
        .PCPlus4_E(s_PCPlus4_E), .Rs1_E(s_Rs1_E), .Rs2_E(s_Rs2_E), .Rd_E(s_Rd_E),
        .bubble_cnt(bubble_cnt4)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // One rising edge, then settle before sampling outputs.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_d();
        valid_D      = 1'($urandom);
        ALUControl_D = 4'($urandom);
        RegWrite_D   = 1'($urandom);
        MemWrite_D   = 1'($urandom);
        Jump_D       = 1'($urandom);
        Branch_D     = 1'($urandom);
        ALUSrc_D     = 1'($urandom);
        ResultSrc_D  = 2'($urandom);
        funct3_D     = 3'($urandom);
        RD1_D        = $urandom;
        RD2_D        = $urandom;
        ImmExt_D     = $urandom;
        PC_D         = $urandom;
        PCPlus4_D    = $urandom;
        Rs1_D        = 5'($urandom);
        Rs2_D        = 5'($urandom);
        Rd_D         = 5'($urandom);
    endtask

    // Checks every EX-side field against the all-zero bubble/reset pattern.
    task automatic chk_zero(input string tag);
        chk({tag, ".valid_E"},      {31'd0, valid_E},      32'd0);
        chk({tag, ".ALUControl_E"}, {28'd0, ALUControl_E}, 32'd0);
        chk({tag, ".ctrl_bits"},    {27'd0, RegWrite_E, MemWrite_E, Jump_E, Branch_E, ALUSrc_E}, 32'd0);
        chk({tag, ".ResultSrc_E"},  {30'd0, ResultSrc_E},  32'd0);
        chk({tag, ".funct3_E"},     {29'd0, funct3_E},     32'd0);
        chk({tag, ".RD1_E"},        RD1_E,                 32'd0);
        chk({tag, ".RD2_E"},        RD2_E,                 32'd0);
        chk({tag, ".ImmExt_E"},     ImmExt_E,              32'd0);
        chk({tag, ".PC_E"},         PC_E,                  32'd0);
        chk({tag, ".PCPlus4_E"},    PCPlus4_E,             32'd0);
        chk({tag, ".regidx"},       {17'd0, Rs1_E, Rs2_E, Rd_E}, 32'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        stall_E = 1'b0;
        flush_E = 1'b0;
        randomize_d();

        // Reset with random D inputs; second cycle also asserts stall+flush, reset must win.
        step();
        randomize_d();
        stall_E = 1'b1;
        flush_E = 1'b1;
        step();
        chk_zero("reset");
        chk("reset.bubble_cnt",  {16'd0, bubble_cnt},  32'd0);
        chk("reset.bubble_cnt4", {28'd0, bubble_cnt4}, 32'd0);

        // Normal load, 1-cycle latency.
        rst_n        = 1'b1;
        stall_E      = 1'b0;
        flush_E      = 1'b0;
        valid_D      = 1'b1;
        ALUControl_D = 4'b0001;
        RD1_D        = 32'h0000_0010;
        RD2_D        = 32'h0000_0003;
        Rd_D         = 5'd5;
        Rs1_D        = 5'd1;
        Rs2_D        = 5'd2;
        RegWrite_D   = 1'b1;
        MemWrite_D   = 1'b0;
        Jump_D       = 1'b0;
        Branch_D     = 1'b1;
        ALUSrc_D     = 1'b1;
        ResultSrc_D  = 2'b10;
        funct3_D     = 3'b011;
        ImmExt_D     = 32'h0000_0123;
        PC_D         = 32'h0000_0100;
        PCPlus4_D    = 32'h0000_0104;
        step();
        chk("load.ALUControl_E", {28'd0, ALUControl_E}, 32'h1);
        chk("load.RD1_E",        RD1_E,                 32'h10);
        chk("load.RD2_E",        RD2_E,                 32'h3);
        chk("load.Rd_E",         {27'd0, Rd_E},         32'd5);
        chk("load.Rs1_Rs2",      {22'd0, Rs1_E, Rs2_E}, {22'd0, 5'd1, 5'd2});
        chk("load.valid_E",      {31'd0, valid_E},      32'd1);
        chk("load.ctrl_bits",    {27'd0, RegWrite_E, MemWrite_E, Jump_E, Branch_E, ALUSrc_E}, 32'b10011);
        chk("load.ResultSrc_E",  {30'd0, ResultSrc_E},  32'd2);
        chk("load.funct3_E",     {29'd0, funct3_E},     32'd3);
        chk("load.ImmExt_E",     ImmExt_E,              32'h123);
        chk("load.PC_E",         PC_E,                  32'h100);
        chk("load.PCPlus4_E",    PCPlus4_E,             32'h104);
        chk("load.bubble_cnt",   {16'd0, bubble_cnt},   32'd0);

        // Stall: 0110 captured, then held for 3 cycles while D moves to 1000.
        ALUControl_D = 4'b0110;
        step();
        chk("stall.pre", {28'd0, ALUControl_E}, 32'h6);
        stall_E      = 1'b1;
        ALUControl_D = 4'b1000;
        RD1_D        = 32'hDEAD_BEEF;
        valid_D      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall.ALUControl_E", {28'd0, ALUControl_E}, 32'h6);
            chk("stall.RD1_E",        RD1_E,                 32'h10);
            chk("stall.valid_E",      {31'd0, valid_E},      32'd1);
        end
        chk("stall.bubble_cnt", {16'd0, bubble_cnt}, 32'd0);
        stall_E = 1'b0;
        valid_D = 1'b1;
        step();
        chk("stall.release", {28'd0, ALUControl_E}, 32'h8);
        chk("stall.rel_RD1", RD1_E,                 32'hDEAD_BEEF);

        // Flush: capture a store to Rd=7, then bubble it.
        MemWrite_D = 1'b1;
        Rd_D       = 5'd7;
        step();
        chk("flush.pre_MemWrite", {31'd0, MemWrite_E}, 32'd1);
        chk("flush.pre_Rd",       {27'd0, Rd_E},       32'd7);
        flush_E = 1'b1;
        step();
        chk_zero("flush");
        chk("flush.bubble_cnt",  {16'd0, bubble_cnt},  32'd1);
        chk("flush.bubble_cnt4", {28'd0, bubble_cnt4}, 32'd1);

        // Flush and stall together: flush wins.
        flush_E = 1'b0;
        step();
        chk("fs.pre_valid", {31'd0, valid_E}, 32'd1);
        flush_E = 1'b1;
        stall_E = 1'b1;
        step();
        chk_zero("fs");
        chk("fs.bubble_cnt", {16'd0, bubble_cnt}, 32'd2);

        // Reserved ALU code passes through unchanged.
        flush_E      = 1'b0;
        stall_E      = 1'b0;
        ALUControl_D = 4'b1011;
        step();
        chk("reserved.ALUControl_E", {28'd0, ALUControl_E}, 32'hB);

        // ID bubble: controls squashed, valid follows valid_D, data still loads.
        valid_D      = 1'b0;
        RegWrite_D   = 1'b1;
        MemWrite_D   = 1'b1;
        Jump_D       = 1'b1;
        Branch_D     = 1'b1;
        ALUSrc_D     = 1'b1;
        RD1_D        = 32'h1234_5678;
        ALUControl_D = 4'b0101;
        step();
        chk("idb.valid_E",      {31'd0, valid_E},      32'd0);
        chk("idb.RegWrite_E",   {31'd0, RegWrite_E},   32'd0);
        chk("idb.ctrl_bits",    {27'd0, RegWrite_E, MemWrite_E, Jump_E, Branch_E, ALUSrc_E}, 32'd0);
        chk("idb.RD1_E",        RD1_E,                 32'h1234_5678);
        chk("idb.ALUControl_E", {28'd0, ALUControl_E}, 32'h5);
        chk("idb.bubble_cnt",   {16'd0, bubble_cnt},   32'd2);

        // Saturation: 20 more flushes; 16-bit counter reaches 22, 4-bit one sticks at 15.
        valid_D = 1'b1;
        flush_E = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
        end
        chk("sat.bubble_cnt4", {28'd0, bubble_cnt4}, 32'd15);
        chk("sat.bubble_cnt",  {16'd0, bubble_cnt},  32'd22);
        step();
        chk("sat.hold4",       {28'd0, bubble_cnt4}, 32'd15);
        chk("sat.bubble_cnt+", {16'd0, bubble_cnt},  32'd23);

        // Stall alone leaves the counter untouched.
        flush_E = 1'b0;
        stall_E = 1'b1;
        step();
        chk("stall_cnt.bubble_cnt", {16'd0, bubble_cnt}, 32'd23);

        // Reset during stall+flush: everything returns to 0.
        rst_n   = 1'b0;
        flush_E = 1'b1;
        randomize_d();
        step();
        chk_zero("rst2");
        chk("rst2.bubble_cnt",  {16'd0, bubble_cnt},  32'd0);
        chk("rst2.bubble_cnt4", {28'd0, bubble_cnt4}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
